ysyx_22040632_axi_rr_arbiter: RTL and testbench

- Parametrised N-channel successor to the two-port icache/dcache arbiter. Arbitrates NCH requesters (icache, dcache, clint/uncached, DMA, ...) onto one AXI4 master.
- Grant is round-robin and is held until the transaction completes.
- Supports read bursts (len up to 255) and single-beat writes. The AXI ID carries the granted channel index.

---
 rtl/ysyx_22040632_axi_rr_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_ysyx_22040632_axi_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_axi_rr_arbiter.sv
// Round-robin arbiter of NCH cache/device requesters onto one AXI4 master.
// Read bursts and single-beat writes; the AXI ID carries the granted channel index.
module ysyx_22040632_axi_rr_arbiter #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned IDW = 4
) (
  input  logic                  clk,
  input  logic                  rrst_n,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH-1:0]        req_wen,
  input  logic [NCH*AW-1:0]     req_addr,
  input  logic [NCH*3-1:0]      req_size,
  input  logic [NCH*8-1:0]      req_len,
  input  logic [NCH*DW-1:0]     req_wdata,
  input  logic [NCH*DW/8-1:0]   req_wstrb,
  output logic [NCH-1:0]        resp_valid,
  output logic [DW-1:0]         resp_data,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic                  axi_aw_valid_o,
  input  logic                  axi_aw_ready_i,
  output logic [AW-1:0]         axi_aw_addr_o,
  output logic [IDW-1:0]        axi_aw_id_o,
  output logic [7:0]            axi_aw_len_o,
  output logic [2:0]            axi_aw_size_o,
  output logic [1:0]            axi_aw_burst_o,
  output logic                  axi_aw_lock_o,
  output logic [3:0]            axi_aw_cache_o,
  output logic [2:0]            axi_aw_prot_o,
  output logic [3:0]            axi_aw_qos_o,
  output logic [3:0]            axi_aw_region_o,
  output logic                  axi_aw_user_o,
  output logic                  axi_w_valid_o,
  input  logic                  axi_w_ready_i,
  output logic [DW-1:0]         axi_w_data_o,
  output logic [DW/8-1:0]       axi_w_strb_o,
  output logic                  axi_w_last_o,
  output logic                  axi_w_user_o,
  output logic                  axi_b_ready_o,
  input  logic                  axi_b_valid_i,
  input  logic [1:0]            axi_b_resp_i,
  input  logic [IDW-1:0]        axi_b_id_i,
  output logic                  axi_ar_valid_o,
  input  logic                  axi_ar_ready_i,
  output logic [AW-1:0]         axi_ar_addr_o,
  output logic [IDW-1:0]        axi_ar_id_o,
  output logic [7:0]            axi_ar_len_o,
  output logic [2:0]            axi_ar_size_o,
  output logic [1:0]            axi_ar_burst_o,
  output logic                  axi_ar_lock_o,
  output logic [3:0]            axi_ar_cache_o,
  output logic [2:0]            axi_ar_prot_o,
  output logic [3:0]            axi_ar_qos_o,
  output logic [3:0]            axi_ar_region_o,
  output logic                  axi_ar_user_o,
  output logic                  axi_r_ready_o,
  input  logic                  axi_r_valid_i,
  input  logic [DW-1:0]         axi_r_data_i,
  input  logic [1:0]            axi_r_resp_i,
  input  logic                  axi_r_last_i,
  input  logic [IDW-1:0]        axi_r_id_i
);

  localparam int unsigned CW = $clog2(NCH);

  typedef enum logic [2:0] {StIdle, StAr, StR, StWr, StB} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     gnt_q, gnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [7:0]        len_q, len_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              gnt_found;
  logic [CW-1:0]     gnt_idx;

  function automatic logic [CW-1:0] wrap_add(logic [CW-1:0] a, int unsigned b);
    return CW'((32'(a) + b) % NCH);
  endfunction

  // First pending channel at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!gnt_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    size_d    = size_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = '0;
    case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = rrst_n;
          gnt_d     = gnt_idx;
          addr_d    = req_addr[32'(gnt_idx)*AW +: AW];
          size_d    = req_size[32'(gnt_idx)*3 +: 3];
          len_d     = req_wen[gnt_idx] ? 8'd0 : req_len[32'(gnt_idx)*8 +: 8];
          wdata_d   = req_wdata[32'(gnt_idx)*DW +: DW];
          wstrb_d   = req_wstrb[32'(gnt_idx)*(DW/8) +: DW/8];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen[gnt_idx] ? StWr : StAr;
        end
      end
      StAr: if (axi_ar_ready_i) state_d = StR;
      StR: begin
        if (axi_r_valid_i && axi_r_last_i) begin
          state_d  = StIdle;
          rr_ptr_d = wrap_add(gnt_q, 1);
        end
      end
      StWr: begin
        // AW and W complete independently; leave only once both have handshaken.
        if (axi_aw_ready_i && !aw_done_q) aw_done_d = 1'b1;
        if (axi_w_ready_i && !w_done_q)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = StB;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StB: begin
        if (axi_b_valid_i) begin
          state_d  = StIdle;
          rr_ptr_d = wrap_add(gnt_q, 1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rrst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    resp_last  = 1'b0;
    resp_err   = 1'b0;
    if (state_q == StR && axi_r_valid_i) begin
      resp_valid[gnt_q] = 1'b1;
      resp_data         = axi_r_data_i;
      resp_last         = axi_r_last_i;
      resp_err          = axi_r_resp_i[1];
    end else if (state_q == StB && axi_b_valid_i) begin
      resp_valid[gnt_q] = 1'b1;
      resp_last         = 1'b1;
      resp_err          = axi_b_resp_i[1];
    end
  end

  assign axi_ar_valid_o  = (state_q == StAr);
  assign axi_ar_addr_o   = addr_q;
  assign axi_ar_id_o     = IDW'(gnt_q);
  assign axi_ar_len_o    = len_q;
  assign axi_ar_size_o   = size_q;
  assign axi_ar_burst_o  = 2'b01;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_cache_o  = 4'b0010;
  assign axi_ar_prot_o   = 3'b000;
  assign axi_ar_qos_o    = 4'b0000;
  assign axi_ar_region_o = 4'b0000;
  assign axi_ar_user_o   = 1'b0;
  assign axi_r_ready_o   = (state_q == StR);

  assign axi_aw_valid_o  = (state_q == StWr) && !aw_done_q;
  assign axi_aw_addr_o   = addr_q;
  assign axi_aw_id_o     = IDW'(gnt_q);
  assign axi_aw_len_o    = 8'd0;
  assign axi_aw_size_o   = size_q;
  assign axi_aw_burst_o  = 2'b01;
  assign axi_aw_lock_o   = 1'b0;
  assign axi_aw_cache_o  = 4'b0010;
  assign axi_aw_prot_o   = 3'b000;
  assign axi_aw_qos_o    = 4'b0000;
  assign axi_aw_region_o = 4'b0000;
  assign axi_aw_user_o   = 1'b0;
  assign axi_w_valid_o   = (state_q == StWr) && !w_done_q;
  assign axi_w_data_o    = wdata_q;
  assign axi_w_strb_o    = wstrb_q;
  assign axi_w_last_o    = 1'b1;
  assign axi_w_user_o    = 1'b0;
  assign axi_b_ready_o   = (state_q == StB);

  // Single outstanding transaction: returned IDs and resp[0] carry no information.
  logic unused_axi;
  assign unused_axi = ^{axi_b_id_i, axi_r_id_i, axi_b_resp_i[0], axi_r_resp_i[0]};

endmodule

// File: tb/tb_ysyx_22040632_axi_rr_arbiter.sv
// Bench for the round-robin AXI arbiter: directed scenarios then random traffic,
// with the bench acting as both the requesters and the AXI slave.
module tb_ysyx_22040632_axi_rr_arbiter;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned IDW = 4;

  logic clk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]      req_valid, req_ready, req_wen, resp_valid;
  logic [NCH*AW-1:0]   req_addr;
  logic [NCH*3-1:0]    req_size;
  logic [NCH*8-1:0]    req_len;
  logic [NCH*DW-1:0]   req_wdata;
  logic [NCH*DW/8-1:0] req_wstrb;
  logic [DW-1:0]       resp_data;
  logic                resp_last, resp_err;
  logic                axi_aw_valid_o, axi_aw_ready_i, axi_aw_lock_o, axi_aw_user_o;
  logic [AW-1:0]       axi_aw_addr_o, axi_ar_addr_o;
  logic [IDW-1:0]      axi_aw_id_o, axi_ar_id_o, axi_b_id_i, axi_r_id_i;
  logic [7:0]          axi_aw_len_o, axi_ar_len_o;
  logic [2:0]          axi_aw_size_o, axi_aw_prot_o, axi_ar_size_o, axi_ar_prot_o;
  logic [1:0]          axi_aw_burst_o, axi_ar_burst_o, axi_b_resp_i, axi_r_resp_i;
  logic [3:0]          axi_aw_cache_o, axi_aw_qos_o, axi_aw_region_o;
  logic [3:0]          axi_ar_cache_o, axi_ar_qos_o, axi_ar_region_o;
  logic                axi_w_valid_o, axi_w_ready_i, axi_w_last_o, axi_w_user_o;
  logic [DW-1:0]       axi_w_data_o, axi_r_data_i;
  logic [DW/8-1:0]     axi_w_strb_o;
  logic                axi_b_ready_o, axi_b_valid_i;
  logic                axi_ar_valid_o, axi_ar_ready_i, axi_ar_lock_o, axi_ar_user_o;
  logic                axi_r_ready_o, axi_r_valid_i, axi_r_last_i;

  ysyx_22040632_axi_rr_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rrst_n(rrst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .resp_err(resp_err),
    .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
    .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_id_o(axi_aw_id_o), .axi_aw_len_o(axi_aw_len_o),
    .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o),
    .axi_aw_lock_o(axi_aw_lock_o), .axi_aw_cache_o(axi_aw_cache_o),
    .axi_aw_prot_o(axi_aw_prot_o), .axi_aw_qos_o(axi_aw_qos_o),
    .axi_aw_region_o(axi_aw_region_o), .axi_aw_user_o(axi_aw_user_o),
    .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i), .axi_w_data_o(axi_w_data_o),
    .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o), .axi_w_user_o(axi_w_user_o),
    .axi_b_ready_o(axi_b_ready_o), .axi_b_valid_i(axi_b_valid_i),
    .axi_b_resp_i(axi_b_resp_i), .axi_b_id_i(axi_b_id_i),
    .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
    .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_id_o(axi_ar_id_o), .axi_ar_len_o(axi_ar_len_o),
    .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o),
    .axi_ar_lock_o(axi_ar_lock_o), .axi_ar_cache_o(axi_ar_cache_o),
    .axi_ar_prot_o(axi_ar_prot_o), .axi_ar_qos_o(axi_ar_qos_o),
    .axi_ar_region_o(axi_ar_region_o), .axi_ar_user_o(axi_ar_user_o),
    .axi_r_ready_o(axi_r_ready_o), .axi_r_valid_i(axi_r_valid_i), .axi_r_data_i(axi_r_data_i),
    .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Requester-side view of each channel's pending request.
  logic [AW-1:0]   m_addr  [NCH];
  logic [2:0]      m_size  [NCH];
  logic [7:0]      m_len   [NCH];
  logic            m_wen   [NCH];
  logic [DW-1:0]   m_wdata [NCH];
  logic [DW/8-1:0] m_wstrb [NCH];

  int ptr;          // model round-robin pointer
  bit keep_req;     // requester re-requests right after acceptance
  bit fixed_beats;  // beat data 0x11, 0x22, ...
  int ar_dly, aw_dly, w_dly;  // -1 = random
  int err_beat;     // -1 random resp, -2 all OKAY, else SLVERR on that beat
  int abort_beat;   // >=0: reset in place of that read beat
  int max_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int k);
    return (k >= 0) ? k : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [NCH-1:0] onehot(input int g);
    logic [NCH-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Reference arbitration rule: first pending channel scanning ptr, ptr+1, ... mod NCH.
  function automatic int model_pick(input int p, input logic [NCH-1:0] m);
    for (int k = 0; k < NCH; k++) if (m[(p + k) % NCH]) return (p + k) % NCH;
    return 0;
  endfunction

  task automatic drive_req();
    for (int c = 0; c < NCH; c++) begin
      req_wen[c]                    = m_wen[c];
      req_addr[c*AW +: AW]          = m_addr[c];
      req_size[c*3 +: 3]            = m_size[c];
      req_len[c*8 +: 8]             = m_len[c];
      req_wdata[c*DW +: DW]         = m_wdata[c];
      req_wstrb[c*(DW/8) +: DW/8]   = m_wstrb[c];
    end
  endtask

  task automatic set_req(input int c, input logic wen, input logic [AW-1:0] addr,
                         input logic [2:0] size, input logic [7:0] len,
                         input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
    m_wen[c] = wen; m_addr[c] = addr; m_size[c] = size; m_len[c] = len;
    m_wdata[c] = wdata; m_wstrb[c] = wstrb;
    req_valid[c] = 1'b1;
    drive_req();
  endtask

  task automatic rand_req(input int c);
    set_req(c, 1'($urandom_range(0, 1)), {$urandom} & ~32'h7, 3'($urandom_range(0, 3)),
            8'($urandom_range(0, max_len)), {$urandom, $urandom}, 8'($urandom));
  endtask

  task automatic quiet(input string tag);
    chk(tag, {req_ready, resp_valid, axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o,
              axi_r_ready_o, axi_b_ready_o, resp_last, resp_err}, '0);
  endtask

  // One full transaction, entered in an IDLE cycle with at least one request pending.
  task automatic do_txn();
    int g, d, da, dw, n, gap;
    logic [AW-1:0] e_addr;
    logic [2:0] e_size;
    logic [7:0] e_len;
    logic e_wen;
    logic [DW-1:0] e_wdata, bd;
    logic [DW/8-1:0] e_wstrb;
    logic [1:0] rr;
    g = model_pick(ptr, req_valid);
    e_wen = m_wen[g]; e_addr = m_addr[g]; e_size = m_size[g];
    e_len = e_wen ? 8'd0 : m_len[g]; e_wdata = m_wdata[g]; e_wstrb = m_wstrb[g];
    #1;
    chk("grant", req_ready, onehot(g));
    chk("idle_quiet", {axi_ar_valid_o, axi_aw_valid_o, axi_w_valid_o, resp_valid}, '0);
    next_cycle();
    if (keep_req) rand_req(g);
    else req_valid[g] = 1'b0;
    if (!e_wen) begin
      d = pick(ar_dly);
      for (int t = 0; t <= d; t++) begin
        axi_ar_ready_i = (t == d);
        #1;
        chk("ar_valid", axi_ar_valid_o, 1);
        chk("ar_addr", axi_ar_addr_o, e_addr);
        chk("ar_ctl", {axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o},
            {IDW'(g), e_len, e_size, 2'b01});
        chk("ar_quiet", {resp_valid, axi_r_ready_o}, '0);
        next_cycle();
      end
      axi_ar_ready_i = 1'b0;
      for (int b = 0; b <= int'(e_len); b++) begin
        gap = $urandom_range(0, 1);
        for (int k = 0; k < gap; k++) begin
          #1;
          chk("r_gap", {axi_r_ready_o, resp_valid, resp_last}, {1'b1, NCH'(0), 1'b0});
          next_cycle();
        end
        if (b == abort_beat) begin
          rrst_n = 1'b0;
          next_cycle();
          quiet("abort_quiet");
          rrst_n = 1'b1;
          ptr = 0;
          return;
        end
        bd = fixed_beats ? DW'((b + 1) * 'h11) : {$urandom, $urandom};
        rr = (err_beat == -1) ? 2'($urandom_range(0, 3)) : ((b == err_beat) ? 2'b10 : 2'b00);
        axi_r_valid_i = 1'b1; axi_r_data_i = bd; axi_r_resp_i = rr;
        axi_r_last_i = (b == int'(e_len));
        #1;
        chk("r_beat_valid", {axi_r_ready_o, resp_valid}, {1'b1, onehot(g)});
        chk("r_beat_data", resp_data, bd);
        chk("r_beat_flags", {resp_last, resp_err}, {b == int'(e_len), rr[1]});
        next_cycle();
        axi_r_valid_i = 1'b0; axi_r_last_i = 1'b0;
      end
    end else begin
      da = pick(aw_dly); dw = pick(w_dly); n = (da > dw) ? da : dw;
      for (int t = 0; t <= n; t++) begin
        axi_aw_ready_i = (t == da); axi_w_ready_i = (t == dw);
        #1;
        chk("aw_valid", axi_aw_valid_o, t <= da);
        chk("w_valid", axi_w_valid_o, t <= dw);
        chk("wr_no_b", {axi_b_ready_o, resp_valid}, '0);
        if (t <= da) begin
          chk("aw_addr", axi_aw_addr_o, e_addr);
          chk("aw_ctl", {axi_aw_id_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o},
              {IDW'(g), 8'd0, e_size, 2'b01});
        end
        if (t <= dw) begin
          chk("w_data", axi_w_data_o, e_wdata);
          chk("w_strb_last", {axi_w_strb_o, axi_w_last_o}, {e_wstrb, 1'b1});
        end
        next_cycle();
      end
      axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0;
      d = pick(-1);
      rr = (err_beat == -1) ? 2'($urandom_range(0, 3)) : 2'b00;
      for (int t = 0; t <= d; t++) begin
        axi_b_valid_i = (t == d); axi_b_resp_i = rr;
        #1;
        chk("b_ready", axi_b_ready_o, 1);
        chk("b_resp_valid", resp_valid, (t == d) ? onehot(g) : '0);
        if (t == d) chk("b_flags", {resp_last, resp_err}, {1'b1, rr[1]});
        next_cycle();
      end
      axi_b_valid_i = 1'b0;
    end
    ptr = (g + 1) % NCH;
  endtask

  initial begin
    req_valid = '0;
    for (int c = 0; c < NCH; c++) begin
      m_wen[c] = 1'b0; m_addr[c] = '0; m_size[c] = '0; m_len[c] = '0;
      m_wdata[c] = '0; m_wstrb[c] = '0;
    end
    drive_req();
    axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_b_valid_i = 0; axi_b_resp_i = 0;
    axi_b_id_i = 0; axi_ar_ready_i = 0; axi_r_valid_i = 0; axi_r_data_i = 0;
    axi_r_resp_i = 0; axi_r_last_i = 0; axi_r_id_i = 0;
    keep_req = 0; fixed_beats = 0; ar_dly = -1; aw_dly = -1; w_dly = -1;
    err_beat = -2; abort_beat = -1; max_len = 7; ptr = 0;

    // Reset state and tie-offs.
    repeat (3) next_cycle();
    quiet("reset_quiet");
    chk("reset_data", resp_data, '0);
    chk("ar_tieoff", {axi_ar_lock_o, axi_ar_cache_o, axi_ar_prot_o, axi_ar_qos_o,
                      axi_ar_region_o, axi_ar_user_o}, {1'b0, 4'b0010, 3'b0, 4'b0, 4'b0, 1'b0});
    chk("aw_tieoff", {axi_aw_lock_o, axi_aw_cache_o, axi_aw_prot_o, axi_aw_qos_o,
                      axi_aw_region_o, axi_aw_user_o, axi_w_user_o},
        {1'b0, 4'b0010, 3'b0, 4'b0, 4'b0, 1'b0, 1'b0});
    rrst_n = 1'b1;
    next_cycle();

    // ch0 4-beat read with beats 0x11..0x44.
    fixed_beats = 1;
    set_req(0, 1'b0, 32'h8000_0000, 3'd3, 8'd3, '0, '0);
    do_txn();
    fixed_beats = 0;
    // Pointer now 1: with both pending, ch1 wins, then ch0.
    set_req(0, 1'b0, 32'h8000_0040, 3'd3, 8'd1, '0, '0);
    set_req(1, 1'b0, 32'h8000_0080, 3'd3, 8'd0, '0, '0);
    do_txn();
    do_txn();

    // Continuous requests on ch0 and ch1 from reset.
    rrst_n = 1'b0;
    keep_req = 1;
    rand_req(0);
    rand_req(1);
    next_cycle();
    next_cycle();
    quiet("reset_with_req_quiet");
    ptr = 0;
    rrst_n = 1'b1;
    repeat (4) do_txn();
    keep_req = 0;
    req_valid = '0;

    // ch1 write; W accepted 3 cycles before AW.
    aw_dly = 3; w_dly = 0;
    set_req(1, 1'b1, 32'h8000_0100, 3'd3, 8'd0, 64'hDEAD_BEEF, 8'h0F);
    do_txn();
    aw_dly = -1; w_dly = -1;

    // 2-beat read with SLVERR on the second beat only.
    err_beat = 1;
    set_req(0, 1'b0, 32'h8000_0200, 3'd3, 8'd1, '0, '0);
    do_txn();
    err_beat = -2;

    // Drive pointer to 2, then ch3 and ch1 together: ch3 first.
    set_req(1, 1'b0, 32'h8000_0300, 3'd2, 8'd0, '0, '0);
    do_txn();
    set_req(3, 1'b0, 32'h8000_0400, 3'd3, 8'd2, '0, '0);
    set_req(1, 1'b1, 32'h8000_0500, 3'd3, 8'd0, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    do_txn();
    do_txn();

    // Pointer to 3, then reset mid-burst: pointer must return to 0.
    set_req(2, 1'b0, 32'h8000_0600, 3'd3, 8'd0, '0, '0);
    do_txn();
    abort_beat = 1;
    set_req(2, 1'b0, 32'h8000_0700, 3'd3, 8'd3, '0, '0);
    do_txn();
    abort_beat = -1;
    set_req(0, 1'b0, 32'h8000_0800, 3'd3, 8'd0, '0, '0);
    set_req(3, 1'b0, 32'h8000_0900, 3'd3, 8'd0, '0, '0);
    do_txn();
    do_txn();

    // Random traffic.
    err_beat = -1; max_len = 15;
    for (int i = 0; i < 40; i++) begin
      if (req_valid == '0) rand_req(int'($urandom_range(0, NCH - 1)));
      do_txn();
      for (int c = 0; c < NCH; c++) if (!req_valid[c] && $urandom_range(0, 1) == 1) rand_req(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
